// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_buffer
//  Description : Byte FIFO with a drain engine that pushes queued bytes into a
//                memory-mapped UART transmitter. The UART is selected through
//                a constant chip select and data-register address. A byte is
//                written only when the UART reports ready (uart_status[0]).
//                Writes are spaced by a one-cycle settle period.
//                Optional feature macro: UART_TX_BUFFER_CRLF_EN
//                  When this macro is defined, each LF (8'h0A) is preceded by
//                  a CR (8'h0D).
//  Revision    : 1.0 - initial release
// ============================================================================

module uart_tx_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              uart_addr,
  output logic [7:0]              uart_data,
  output logic                    uart_we,
  output logic                    uart_cs,
  input  logic [7:0]              uart_status,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
  localparam logic [7:0] UART_DATA_REG = 8'h00;

  // Drain engine states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic              tx_ready;
  logic [7:0]        head;
  logic [7:0]        emit_byte;

  // Only the transmitter-ready bit of the UART status is meaningful here
  logic              unused_status_bits;
  assign unused_status_bits = &{1'b0, uart_status[7:1]};

  assign tx_ready  = uart_status[0];
  assign uart_addr = UART_DATA_REG;
  assign uart_cs   = 1'b1;

  // Ready depends only on the registered occupancy, never on in_valid
  assign in_ready = (level != FULL_LEVEL);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

`ifdef UART_TX_BUFFER_CRLF_EN
  // cr_sent marks that the CR for the LF at the head has already gone out
  logic cr_sent;
  logic insert_cr;

  assign insert_cr = (head == 8'h0A) && !cr_sent;
  assign emit_byte = insert_cr ? 8'h0D : head;
  // An inserted CR leaves the LF at the head for the next write
  assign pop       = (state == WRITE) && !insert_cr;

  // Remember that the CR has been sent so the following write emits the LF
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_sent <= 1'b0;
    end else if (state == WRITE) begin
      cr_sent <= insert_cr;
    end
  end
`else
  assign emit_byte = head;
  assign pop       = (state == WRITE);
`endif

  // Storage array. It is not reset, because only bytes below level are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // A simultaneous push and pop cancel out in the occupancy count
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (!push && pop) begin
        level <= level - LVL_W'(1);
      end
      // A byte that is offered while the FIFO is full is dropped, even if a pop happens in the same cycle
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // Drain FSM with registered strobe and data; uart_data keeps its last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      uart_we   <= 1'b0;
      uart_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          uart_we <= 1'b0;
          if ((level != '0) && tx_ready) begin
            state     <= WRITE;
            uart_we   <= 1'b1;
            uart_data <= emit_byte;
          end
        end
        WRITE: begin
          state   <= SETTLE;
          uart_we <= 1'b0;
        end
        SETTLE: begin
          state   <= IDLE;
          uart_we <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          uart_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_buffer
//  Description : Self-checking bench for uart_tx_buffer. A cycle-level
//                reference model predicts the strobe timing. A byte queue
//                predicts the emitted data, the level and the flags.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_uart_tx_buffer;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    uart_addr;
  logic [7:0]    uart_data;
  logic          uart_we;
  logic          uart_cs;
  logic [7:0]    status_drv = 8'h00;
  logic [LW-1:0] level;
  logic          overflow;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_we = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_wrote_cr = 1'b0;
`ifdef UART_TX_BUFFER_CRLF_EN
  bit         m_cr_sent = 1'b0;
`endif
  int         cyc = 0;
  int         last_we = -100;

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .uart_addr   (uart_addr),
    .uart_data   (uart_data),
    .uart_we     (uart_we),
    .uart_cs     (uart_cs),
    .uart_status (status_drv),
    .level       (level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("uart_we",   32'(uart_we),   32'(m_we));
    check("uart_data", 32'(uart_data), 32'(m_data));
    check("level",     32'(level),     32'(q.size()));
    check("in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("uart_addr", 32'(uart_addr), 32'h00);
    check("uart_cs",   32'(uart_cs),   32'h1);
  endtask

  // One clock: the model advances with the inputs held over the edge, and the outputs are checked 1ns later
  task automatic step();
    bit         push_ok;
    bit         we_n;
    bit         wrote_cr_n;
    logic [7:0] d_n;
    @(posedge clk);
    if (rst_n) begin
      push_ok = in_valid && (q.size() < DEPTH);
      if (in_valid && q.size() == DEPTH) m_ovf = 1'b1;
      // A write needs 3 cycles since the last one, a non-empty FIFO and ready in the deciding cycle
      we_n = ((cyc + 1 - last_we) >= 3) && (q.size() != 0) && status_drv[0];
      d_n = m_data;
      wrote_cr_n = 1'b0;
      if (we_n) begin
        d_n = q[0];
`ifdef UART_TX_BUFFER_CRLF_EN
        if (q[0] == 8'h0A && !m_cr_sent) begin
          d_n = 8'h0D;
          wrote_cr_n = 1'b1;
        end
`endif
        last_we = cyc + 1;
      end
      if (m_we) begin
        if (!m_wrote_cr) void'(q.pop_front());
`ifdef UART_TX_BUFFER_CRLF_EN
        m_cr_sent = m_wrote_cr;
`endif
      end
      if (push_ok) q.push_back(in_data);
      m_we = we_n;
      m_data = d_n;
      m_wrote_cr = wrote_cr_n;
    end
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic push_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int k = 0;
    while ((q.size() != 0 || m_we) && k < max_cycles) begin
      step();
      k++;
    end
    step();
    step();
    check("drain_level", 32'(level), 32'h0);
    check("drain_we", 32'(uart_we), 32'h0);
  endtask

  // Asynchronous reset asserted in the middle of a cycle and released on a falling edge
  task automatic async_reset();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_we",       32'(uart_we),   32'h0);
    check("rst_level",    32'(level),     32'h0);
    check("rst_overflow", 32'(overflow),  32'h0);
    check("rst_data",     32'(uart_data), 32'h00);
    check("rst_in_ready", 32'(in_ready),  32'h1);
    q.delete();
    m_we = 1'b0;
    m_data = 8'h00;
    m_ovf = 1'b0;
    m_wrote_cr = 1'b0;
`ifdef UART_TX_BUFFER_CRLF_EN
    m_cr_sent = 1'b0;
`endif
    last_we = -100;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    async_reset();

    // Single byte: the strobe is expected two cycles after the push
    status_drv = 8'h01;
    push_byte(8'h41);
    check("lat_n1_we", 32'(uart_we), 32'h0);
    step();
    check("lat_n2_we", 32'(uart_we), 32'h1);
    check("lat_n2_data", 32'(uart_data), 32'h41);
    step();
    check("lat_level_after", 32'(level), 32'h0);
    check("hold_data", 32'(uart_data), 32'h41);
    drain(10);

    // Back-to-back pushes of A..D
    for (int i = 0; i < 4; i++) push_byte(8'h41 + 8'(i));
    drain(40);

    // Fill while the UART is busy, then offer one extra byte to force an overflow
    status_drv = 8'h00;
    for (int i = 0; i < DEPTH + 1; i++) push_byte(8'($urandom));
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_in_ready", 32'(in_ready), 32'h0);
    check("full_overflow", 32'(overflow), 32'h1);
    check("full_no_we", 32'(uart_we), 32'h0);
    // Offer a byte while full in the same cycle that the first pop happens
    status_drv = 8'h01;
    step();
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    step();
    in_valid = 1'b0;
    drain(DEPTH * 4 + 10);

    // Ready toggles every 5 cycles while the producer pushes at random
    for (int i = 0; i < 200; i++) begin
      status_drv = {7'($urandom), 1'(((i / 5) % 2) == 1)};
      in_valid = 1'($urandom_range(0, 2) == 0);
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    status_drv = 8'h01;
    drain(DEPTH * 4 + 10);

    // Reset during a WRITE while three bytes are queued
    status_drv = 8'h00;
    for (int i = 0; i < 3; i++) push_byte(8'h60 + 8'(i));
    status_drv = 8'h01;
    k = 0;
    while (!m_we && k < 10) begin
      step();
      k++;
    end
    check("reach_write", 32'(m_we), 32'h1);
    check("write_level", 32'(level), 32'h3);
    async_reset();
    push_byte(8'h5A);
    drain(10);

    // Line feed: a single write without CRLF insertion, or CR followed by LF with it
    push_byte(8'h0A);
    drain(12);

    // Random traffic with a mostly ready UART and noise in the unused status bits
    for (int i = 0; i < 300; i++) begin
      status_drv = {7'($urandom), 1'($urandom_range(0, 3) != 0)};
      in_valid = 1'($urandom_range(0, 1));
      in_data = (($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom));
      step();
    end
    in_valid = 1'b0;
    status_drv = 8'h01;
    drain(DEPTH * 6 + 10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
- REQ-001 The module SHALL have parameter DEPTH, default 16, meaning FIFO depth in bytes, power of two, range 2..256.
- REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all flops SHALL clock on its rising edge.
- REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
- REQ-004 The module SHALL have port in_data, input, 8 bits: byte offered by the producer.
- REQ-005 The module SHALL have port in_valid, input, 1 bit: in_data valid this cycle.
- REQ-006 The module SHALL have port in_ready, output, 1 bit: buffer can accept a byte this cycle.
- REQ-007 The module SHALL have port uart_addr, output, 8 bits: UART register select, constant 8'h00 (data register).
- REQ-008 The module SHALL have port uart_data, output, 8 bits: byte written to the UART.
- REQ-009 The module SHALL have port uart_we, output, 1 bit: one-cycle UART write strobe.
- REQ-010 The module SHALL have port uart_cs, output, 1 bit: UART chip select, constant 1.
- REQ-011 The module SHALL have port uart_status, input, 8 bits: UART data_out; bit 0 = transmitter ready.
- REQ-012 The module SHALL have port level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
- REQ-013 The module SHALL have port overflow, output, 1 bit: sticky flag, set when a byte is offered while full.

Function
- REQ-014 The module SHALL accept a byte, called a push, when in_valid && in_ready at a rising edge; in_ready SHALL equal (level != DEPTH) and be combinational from registered state only.
- REQ-015 When in_valid=1 and level=DEPTH, the module SHALL drop the byte, set overflow, and leave FIFO contents unchanged; this holds even in a cycle where a pop occurs.
- REQ-016 When a push and a pop occur in the same cycle with level<DEPTH, the module SHALL leave level unchanged and preserve byte order.
- REQ-017 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor underflow below 0.
- REQ-018 The drain FSM SHALL have states IDLE, WRITE and SETTLE.
- REQ-019 In IDLE, when level!=0 and uart_status[0]=1, the FSM SHALL go to WRITE; otherwise it SHALL stay in IDLE.
- REQ-020 In WRITE, the module SHALL drive uart_we=1 with uart_data equal to the head byte, registered. The head byte SHALL be popped at the end of the cycle and the FSM SHALL go to SETTLE.
- REQ-021 In SETTLE, the module SHALL hold uart_we=0 for exactly one cycle, ignoring uart_status, then go to IDLE. Consecutive writes SHALL therefore be at least 3 cycles apart.
- REQ-022 Latency: for a push in cycle N into an empty FIFO with uart_status[0]=1, uart_we SHALL be high in cycle N+2.
- REQ-023 uart_we SHALL never be asserted while level=0 or while uart_status[0] was 0 in the deciding IDLE cycle.
- REQ-024 uart_data SHALL hold its last written value when uart_we=0.

Reset
- REQ-025 Asserting rst_n=0 at any time, including mid-WRITE or SETTLE, SHALL immediately clear the state to IDLE, clear both pointers, set level=0, overflow=0, uart_we=0, uart_data=8'h00, and in_ready=1 once level=0. FIFO RAM contents need not be cleared.
- REQ-026 After rst_n deasserts, the first push SHALL be accepted on the first rising edge.

Configuration
- REQ-027 When macro UART_TX_BUFFER_CRLF_EN is defined and the head byte is 8'h0A, the first WRITE SHALL emit 8'h0D without popping and set an internal cr_sent flag. The next WRITE SHALL emit 8'h0A, pop, and clear cr_sent. cr_sent SHALL reset to 0.
- REQ-028 When UART_TX_BUFFER_CRLF_EN is undefined, all bytes SHALL be emitted verbatim and no cr_sent logic SHALL exist.

Verification
- REQ-029 Scenario: reset, uart_status=8'h01, push 8'h41 in cycle N -> uart_we=1 with uart_data=8'h41 in cycle N+2, then level=0.
- REQ-030 Scenario: push 8'h41..8'h44 back-to-back, status held 1 -> four strobes in order A, B, C, D, each 3 cycles apart.
- REQ-031 Scenario: status=0, push DEPTH+1 bytes -> in_ready=0 after 16 pushes, overflow=1, level=16, no uart_we. Then status=1 -> exactly 16 bytes emitted in order.
- REQ-032 Scenario: status toggles 0/1 every 5 cycles -> a strobe occurs only after an IDLE cycle with status[0]=1, and no byte is lost.
- REQ-033 Scenario: rst_n pulsed low during WRITE with level=3 -> uart_we=0 and level=0 immediately, overflow=0, and the next push is emitted normally.
- REQ-034 Scenario: with CRLF_EN defined, push 8'h0A -> writes 8'h0D then 8'h0A. Without CRLF_EN -> a single write of 8'h0A.
